// File: rtl/npc_btb_unit.sv
// Next-PC unit: owns the fetch PC and predicts the next PC from a direct-mapped
// BTB with 2-bit saturating counters. Redirects fetch on a resolved mispredict.
module npc_btb_unit #(
    parameter int unsigned ENTRIES  = 16,
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter logic [1:0]  CTR_INIT = 2'b01
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        res_valid,
    input  logic [31:0] res_pc,
    input  logic        res_taken,
    input  logic [31:0] res_target,
    input  logic        res_pred_taken,
    input  logic [31:0] res_pred_tgt,
    output logic        redirect
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = 32 - IDX_W - 2;

    logic [31:0]      pc_q;
    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;
    logic [IDX_W-1:0] rs_idx;
    logic [TAG_W-1:0] rs_tag;
    logic             rs_hit;
    logic [31:0]      actual_next;
    logic [31:0]      pc_next;

    // res_pc[1:0] and the carried prediction bit do not affect any decision.
    logic unused_ok;
    assign unused_ok = ^{res_pc[1:0], res_pred_taken};

    // Zero-latency lookup on the current fetch PC.
    always_comb begin
        lk_idx      = pc_q[IDX_W+1:2];
        lk_tag      = pc_q[31:IDX_W+2];
        lk_hit      = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        pc4         = pc_q + 32'd4;
        pred_taken  = lk_hit && ctr_q[lk_idx][1];
        pred_target = pred_taken ? target_q[lk_idx] : pc4;
        pc          = pc_q;
    end

    // Mispredict detection and next-PC selection (redirect beats stall).
    always_comb begin
        rs_idx      = res_pc[IDX_W+1:2];
        rs_tag      = res_pc[31:IDX_W+2];
        rs_hit      = valid_q[rs_idx] && (tag_q[rs_idx] == rs_tag);
        actual_next = res_taken ? res_target : (res_pc + 32'd4);
        redirect    = res_valid && (actual_next != res_pred_tgt);
        if (redirect) begin
            pc_next = actual_next;
        end else if (stall) begin
            pc_next = pc_q;
        end else begin
            pc_next = pred_target;
        end
    end

    // Fetch PC register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= PC_RESET;
        end else begin
            pc_q <= pc_next;
        end
    end

    // BTB training from the resolve stage; visible to lookup next cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_INIT;
            end
        end else if (res_valid) begin
            if (rs_hit) begin
                if (res_taken) begin
                    if (ctr_q[rs_idx] != 2'd3) begin
                        ctr_q[rs_idx] <= ctr_q[rs_idx] + 2'd1;
                    end
                    target_q[rs_idx] <= res_target;
                end else if (ctr_q[rs_idx] != 2'd0) begin
                    ctr_q[rs_idx] <= ctr_q[rs_idx] - 2'd1;
                end
            end else if (res_taken) begin
                valid_q[rs_idx]  <= 1'b1;
                tag_q[rs_idx]    <= rs_tag;
                target_q[rs_idx] <= res_target;
                ctr_q[rs_idx]    <= 2'b10;
            end
        end
    end

endmodule

// File: tb/tb_npc_btb_unit.sv
// Self-checking bench for npc_btb_unit: directed resolves with a PC scoreboard.
module tb_npc_btb_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        res_valid;
    logic [31:0] res_pc;
    logic        res_taken;
    logic [31:0] res_target;
    logic        res_pred_taken;
    logic [31:0] res_pred_tgt;
    logic        redirect;

    typedef struct {
        string       tag;
        logic [31:0] pc;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    npc_btb_unit #(
        .ENTRIES (16),
        .PC_RESET(32'h0000_3000),
        .CTR_INIT(2'b01)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .pc            (pc),
        .pc4           (pc4),
        .pred_taken    (pred_taken),
        .pred_target   (pred_target),
        .res_valid     (res_valid),
        .res_pc        (res_pc),
        .res_taken     (res_taken),
        .res_target    (res_target),
        .res_pred_taken(res_pred_taken),
        .res_pred_tgt  (res_pred_tgt),
        .redirect      (redirect)
    );

    always #5 clk = ~clk;

    // Compare one observed value against its expectation.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle();
        res_valid      = 1'b0;
        res_pc         = 32'h0;
        res_taken      = 1'b0;
        res_target     = 32'h0;
        res_pred_taken = 1'b0;
        res_pred_tgt   = 32'h0;
    endtask

    task automatic resolve(input logic [31:0] rpc, input logic tk, input logic [31:0] tgt,
                           input logic ptk, input logic [31:0] ptgt);
        res_valid      = 1'b1;
        res_pc         = rpc;
        res_taken      = tk;
        res_target     = tgt;
        res_pred_taken = ptk;
        res_pred_tgt   = ptgt;
    endtask

    // Push the expected post-edge PC, clock once, pop and compare.
    task automatic step(input string tag, input logic [31:0] exp_pc);
        exp_t e;
        e.tag = tag;
        e.pc  = exp_pc;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check({tag, " sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check(e.tag, pc, e.pc);
        end
        idle();
    endtask

    // Force fetch to addr with a not-taken resolve whose carried prediction was wrong.
    task automatic jump(input string tag, input logic [31:0] addr);
        resolve(addr - 32'd4, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        check({tag, " redirect"}, 32'(redirect), 32'd1);
        step(tag, addr);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        #12;
        check("rst pc", pc, 32'h3000);
        check("rst pc4", pc4, 32'h3004);
        check("rst pred_taken", 32'(pred_taken), 32'd0);
        check("rst pred_target", pred_target, 32'h3004);
        check("rst redirect", 32'(redirect), 32'd0);
        reset = 1'b1;
        step("adv1", 32'h3004);
        step("adv2", 32'h3008);

        // Stall holds, redirect overrides stall.
        stall = 1'b1;
        for (int i = 0; i < 3; i++) step("stall hold", 32'h3008);
        jump("stall redir", 32'h3100);
        stall = 1'b0;

        // Taken mispredict allocates and redirects; later lookup hits.
        resolve(32'h3010, 1'b1, 32'h3040, 1'b0, 32'h3014);
        #1;
        check("alloc redirect", 32'(redirect), 32'd1);
        step("alloc pc", 32'h3040);
        jump("to 3010", 32'h3010);
        check("hit pred_taken", 32'(pred_taken), 32'd1);
        check("hit pred_target", pred_target, 32'h3040);
        step("follow pred", 32'h3040);

        // Not-taken training: same-cycle lookup sees old counter, saturates at 0.
        jump("to 3010 b", 32'h3010);
        stall = 1'b1;
        resolve(32'h3010, 1'b0, 32'h0, 1'b1, 32'h3014);
        #1;
        check("nt1 redirect", 32'(redirect), 32'd0);
        check("nt1 same-cycle old", 32'(pred_taken), 32'd1);
        step("nt1 pc", 32'h3010);
        #1;
        check("nt1 next pred", 32'(pred_taken), 32'd0);
        check("nt1 next target", pred_target, 32'h3014);
        for (int i = 0; i < 3; i++) begin
            resolve(32'h3010, 1'b0, 32'h0, 1'b0, 32'h3014);
            step("ntN pc", 32'h3010);
            #1;
            check("ntN pred", 32'(pred_taken), 32'd0);
        end
        resolve(32'h3010, 1'b1, 32'h3040, 1'b0, 32'h3040);
        #1;
        check("t1 redirect", 32'(redirect), 32'd0);
        step("t1 pc", 32'h3010);
        #1;
        check("sat t1 pred", 32'(pred_taken), 32'd0);
        resolve(32'h3010, 1'b1, 32'h3040, 1'b0, 32'h3040);
        step("t2 pc", 32'h3010);
        #1;
        check("sat t2 pred", 32'(pred_taken), 32'd1);
        check("sat t2 target", pred_target, 32'h3040);

        // Same index, new tag replaces occupant.
        resolve(32'h3050, 1'b1, 32'h3080, 1'b0, 32'h3054);
        #1;
        check("repl redirect", 32'(redirect), 32'd1);
        step("repl pc", 32'h3080);
        jump("to 3010 c", 32'h3010);
        check("old tag miss", 32'(pred_taken), 32'd0);
        check("old tag target", pred_target, 32'h3014);
        jump("to 3050", 32'h3050);
        check("new tag hit", 32'(pred_taken), 32'd1);
        check("new tag target", pred_target, 32'h3080);

        // Mid-run reset clears PC and BTB.
        reset = 1'b0;
        #1;
        check("mid rst pc", pc, 32'h3000);
        check("mid rst pred", 32'(pred_taken), 32'd0);
        #1;
        reset = 1'b1;
        stall = 1'b0;
        step("mid adv1", 32'h3004);
        step("mid adv2", 32'h3008);
        jump("to 3050 b", 32'h3050);
        check("btb cleared pred", 32'(pred_taken), 32'd0);
        check("btb cleared target", pred_target, 32'h3054);

        // Wrap-around of pc4 and actual_next.
        jump("to top", 32'hFFFF_FFFC);
        check("wrap pc4", pc4, 32'h0);
        check("wrap pred_target", pred_target, 32'h0);
        step("wrap pc", 32'h0);
        jump("to top b", 32'hFFFF_FFFC);
        resolve(32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 32'h1234);
        #1;
        check("wrap redirect", 32'(redirect), 32'd1);
        step("wrap actual", 32'h0);

        // Unaligned redirect target loads as given.
        resolve(32'h2000, 1'b1, 32'h3003, 1'b0, 32'h2004);
        #1;
        check("unal redirect", 32'(redirect), 32'd1);
        step("unal pc", 32'h3003);
        #1;
        check("unal pc4", pc4, 32'h3007);
        check("unal pred_target", pred_target, 32'h3007);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
